// File: rtl/img_cap_pkg.sv
// Shared image-capture definitions: active-level constants and the frame-buffer
// read FSM state type.
package img_cap_pkg;

   localparam logic ASSERT_L   = 1'b0;
   localparam logic DEASSERT_L = 1'b1;
   localparam logic ASSERT_H   = 1'b1;
   localparam logic DEASSERT_H = 1'b0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } fb_rd_state_t;

endpackage

// File: rtl/fb_rd_ctrl_if.sv
// Frame-buffer read bundle: capture-controller handshake, Avalon-MM read port and
// the pixel stream toward the output FIFO.
interface fb_rd_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 25,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  rd_en;
   logic                  avl_ready;
   logic                  avl_read;
   logic [ADDR_WIDTH-1:0] avl_address;
   logic                  avl_readdatavalid;
   logic [DATA_WIDTH-1:0] avl_readdata;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_data_valid;
   logic                  rd_done;

   modport master (
      input  rd_en, avl_ready, avl_readdatavalid, avl_readdata,
      output avl_read, avl_address, rd_data, rd_data_valid, rd_done
   );

   modport slave (
      output rd_en, avl_ready, avl_readdatavalid, avl_readdata,
      input  avl_read, avl_address, rd_data, rd_data_valid, rd_done
   );
endinterface

// File: rtl/fb_rd_credit.sv
// Outstanding-read credit counter: +1 per accepted read, -1 per return,
// saturating at zero, with a registered zero flag and a look-ahead full flag.
module fb_rd_credit #(
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic inc_i,
   input  logic dec_i,
   output logic zero_o,
   output logic full_nxt_c_o
);
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   logic [OW-1:0] cnt_q, cnt_d;
   logic          zero_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i)
         cnt_d = cnt_q + OW'(1);
      else if (dec_i && !inc_i && (cnt_q != '0))
         cnt_d = cnt_q - OW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= (cnt_d == '0);
      end
   end

   assign zero_o       = zero_q;
   assign full_nxt_c_o = (cnt_d >= OW'(MAX_OUTSTANDING));
endmodule

// File: rtl/fb_rd_ctrl.sv
// Frame-buffer read master: reads one frame of words over Avalon-MM and forwards
// returns as a pixel stream. Define FB_RD_REPEAT_EN to re-read the frame while rd_en stays low.
module fb_rd_ctrl
   import img_cap_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 25,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned BASE_ADDR       = 0,
   parameter int unsigned FRAME_WORDS     = 307200,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic         clk,
   input  logic         reset,
   fb_rd_ctrl_if.master bus
);
   localparam int unsigned CW = $clog2(FRAME_WORDS + 1);

   fb_rd_state_t          state_q;
   logic [CW-1:0]         issued_q, issued_d;
   logic [CW-1:0]         returned_q, returned_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  read_q, read_d;
   logic                  rd_valid_q;
   logic                  done_q;
   logic                  accept, ret;
   logic                  cr_zero, cr_full_nxt;

   // Returns are only honoured while reads are owed; strays after a reset are dropped.
   assign accept     = read_q & bus.avl_ready;
   assign ret        = bus.avl_readdatavalid & ~cr_zero;
   assign issued_d   = issued_q + CW'(accept);
   assign returned_d = returned_q + CW'(ret);

   // A pending request holds until accepted; otherwise look ahead one edge.
   assign read_d = (read_q & ~bus.avl_ready) |
                   ((bus.rd_en == ASSERT_L) & (issued_d < CW'(FRAME_WORDS)) & ~cr_full_nxt);

   fb_rd_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
      .clk          (clk),
      .reset        (reset),
      .inc_i        (accept),
      .dec_i        (ret),
      .zero_o       (cr_zero),
      .full_nxt_c_o (cr_full_nxt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         read_q     <= DEASSERT_H;
         addr_q     <= ADDR_WIDTH'(BASE_ADDR);
         issued_q   <= '0;
         returned_q <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= DEASSERT_H;
         done_q     <= ASSERT_H;
      end else begin
         rd_valid_q <= ret;
         if (ret)
            rd_data_q <= bus.avl_readdata;
         issued_q   <= issued_d;
         returned_q <= returned_d;
         if (accept) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            done_q <= DEASSERT_H;
         end

         unique case (state_q)
            S_IDLE: begin
               read_q <= DEASSERT_H;
               if (bus.rd_en == ASSERT_L) begin
                  state_q <= S_ISSUE;
                  read_q  <= read_d;
               end
            end
            S_ISSUE: begin
               read_q <= read_d;
               if (issued_d == CW'(FRAME_WORDS))
                  state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               read_q <= DEASSERT_H;
               // Done is entered one edge after the last return so rd_done trails rd_data_valid.
               if (returned_q == CW'(FRAME_WORDS)) begin
                  state_q    <= S_DONE;
                  done_q     <= ASSERT_H;
                  addr_q     <= ADDR_WIDTH'(BASE_ADDR);
                  issued_q   <= '0;
                  returned_q <= '0;
               end
            end
            S_DONE: begin
               read_q <= DEASSERT_H;
               addr_q <= ADDR_WIDTH'(BASE_ADDR);
               if (bus.rd_en == DEASSERT_L)
                  state_q <= S_IDLE;
`ifdef FB_RD_REPEAT_EN
               else begin
                  state_q <= S_ISSUE;
                  read_q  <= read_d;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.avl_read      = read_q;
   assign bus.avl_address   = addr_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.rd_data_valid = rd_valid_q;
   assign bus.rd_done       = done_q;
endmodule

// File: tb/tb_fb_rd_ctrl.sv
// Randomised and directed bench for fb_rd_ctrl against a rule-level model of the
// read master (frame position, owed returns, forwarded data queue, done timing).
module tb_fb_rd_ctrl;
   localparam int unsigned AW   = 25;
   localparam int unsigned DW   = 32;
   localparam int unsigned FW   = 16;
   localparam int unsigned MAXO = 4;
   localparam int unsigned BASE = 32'h100;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fb_rd_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   fb_rd_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
      .FRAME_WORDS(FW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct { logic [31:0] data; int due; } ret_t;
   ret_t mem_q[$];

   int total = 0, bad = 0;
   int cyc = 0;
   // model state
   int n_iss = 0, ret_cnt = 0, outst = 0, frames_done = 0;
   bit exp_done = 1'b1, exp_v = 1'b0, done_cd = 1'b0;
   logic [31:0] exp_d = '0;
   // observation
   int acc_cnt = 0, fwd_cnt = 0;
   logic [31:0] last_acc_addr = '0;
   logic prev_read = 1'b0, prev_ready = 1'b0, prev_rd_en = 1'b1, prev_reset = 1'b1;
   logic [AW-1:0] prev_addr = '0;
   // stimulus knobs
   logic drv_rd_en = 1'b1, drv_reset = 1'b1;
   int ready_mode = 0, lat_fix = 2;
   bit ret_hold = 0, rnd_ret = 0, rnd_lat = 0, rnd_en = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic sample_check();
      @(negedge clk);
      cyc++;
      chk("rd_data_valid", 64'(bus.rd_data_valid), 64'(exp_v));
      if (exp_v) chk("rd_data", 64'(bus.rd_data), 64'(exp_d));
      chk("rd_done", 64'(bus.rd_done), 64'(exp_done));
      if (bus.avl_read === 1'b1) begin
         chk("avl_address", 64'(bus.avl_address), 64'(BASE + n_iss));
         chk("credit_room", 64'((outst < MAXO) && (n_iss < FW)), 64'd1);
      end
      if (prev_read && !prev_ready && !prev_reset) begin
         chk("read_hold", 64'(bus.avl_read), 64'd1);
         chk("addr_hold", 64'(bus.avl_address), 64'(prev_addr));
      end else if (bus.avl_read === 1'b1 && !prev_reset) begin
         chk("raise_needs_en", 64'(prev_rd_en), 64'd0);
      end
   endtask

   task automatic drive_update();
      logic acc, pres;
      logic [31:0] d;
      ret_t r;
      if (rnd_en && $urandom_range(0, 19) == 0) drv_rd_en = ~drv_rd_en;
      bus.rd_en = drv_rd_en;
      reset     = drv_reset;
      case (ready_mode)
         0:       bus.avl_ready = 1'b1;
         1:       bus.avl_ready = 1'b0;
         default: bus.avl_ready = ($urandom_range(0, 9) < 7);
      endcase
      pres = 1'b0;
      d    = '0;
      if (!ret_hold && !drv_reset && mem_q.size() > 0 && mem_q[0].due <= cyc &&
          (!rnd_ret || $urandom_range(0, 4) != 0)) begin
         pres = 1'b1;
         d    = mem_q[0].data;
         void'(mem_q.pop_front());
      end
      bus.avl_readdatavalid = pres;
      bus.avl_readdata      = pres ? d : $urandom();
      acc = (bus.avl_read === 1'b1) && bus.avl_ready && !drv_reset;

      if (drv_reset) begin
         n_iss = 0; ret_cnt = 0; outst = 0;
         exp_done = 1'b1; exp_v = 1'b0; done_cd = 1'b0;
      end else begin
         if (done_cd) begin
            exp_done = 1'b1; n_iss = 0; ret_cnt = 0; done_cd = 1'b0;
            frames_done++;
         end
         exp_v = 1'b0;
         if (pres && outst > 0) begin
            outst--; exp_v = 1'b1; exp_d = d; ret_cnt++; fwd_cnt++;
            if (ret_cnt == FW) done_cd = 1'b1;
         end
         if (acc) begin
            r.data = $urandom();
            r.due  = cyc + (rnd_lat ? int'($urandom_range(1, 4)) : lat_fix);
            mem_q.push_back(r);
            last_acc_addr = 32'(bus.avl_address);
            acc_cnt++; n_iss++; outst++;
            exp_done = 1'b0;
         end
      end
      prev_read  = bus.avl_read;
      prev_ready = bus.avl_ready;
      prev_addr  = bus.avl_address;
      prev_rd_en = drv_rd_en;
      prev_reset = drv_reset;
   endtask

   task automatic step();
      sample_check();
      drive_update();
   endtask

   task automatic wait_frame(input int budget);
      int target = frames_done + 1;
      for (int i = 0; i < budget && frames_done < target; i++) step();
      chk("frame_within_budget", 64'(frames_done >= target), 64'd1);
   endtask

   task automatic wait_acc(input int n, input int budget);
      for (int i = 0; i < budget && acc_cnt < n; i++) step();
      chk("accepts_within_budget", 64'(acc_cnt >= n), 64'd1);
   endtask

   // Release rd_en in the very cycle the request for stop_addr is on the bus.
   task automatic stop_after(input logic [31:0] stop_addr, input int n, input int budget);
      for (int i = 0; i < budget && acc_cnt < n; i++) begin
         sample_check();
         if (bus.avl_read === 1'b1 && 32'(bus.avl_address) == stop_addr) drv_rd_en = 1'b1;
         drive_update();
      end
      chk("stop_within_budget", 64'(acc_cnt), 64'(n));
   endtask

   task automatic go_idle();
      drv_rd_en = 1'b1;
      repeat (3) step();
   endtask

   initial begin
      bus.rd_en = 1'b1; bus.avl_ready = 1'b0;
      bus.avl_readdatavalid = 1'b0; bus.avl_readdata = '0;
      reset = 1'b1;
      drv_reset = 1'b1;
      repeat (3) begin @(negedge clk); drive_update(); end
      drv_reset = 1'b0;

      // reset values
      sample_check();
      chk("rst_avl_read", 64'(bus.avl_read), 64'd0);
      chk("rst_avl_address", 64'(bus.avl_address), 64'h100);
      chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
      chk("rst_rd_data_valid", 64'(bus.rd_data_valid), 64'd0);
      chk("rst_rd_done", 64'(bus.rd_done), 64'd1);
      drive_update();

      // full frame, ready=1, 2-cycle latency
      acc_cnt = 0; fwd_cnt = 0; lat_fix = 2; drv_rd_en = 1'b0;
      sample_check();
      drive_update();
      sample_check();
      chk("first_read_addr", 64'(bus.avl_address), 64'h100);
      chk("first_read_raised", 64'(bus.avl_read), 64'd1);
      drive_update();
      wait_frame(200);
      chk("s1_accepts", 64'(acc_cnt), 64'd16);
      chk("s1_forwarded", 64'(fwd_cnt), 64'd16);
      chk("s1_last_addr", 64'(last_acc_addr), 64'h10f);
      step();
      chk("s1_done", 64'(bus.rd_done), 64'd1);
`ifdef FB_RD_REPEAT_EN
      sample_check();
      chk("repeat_read", 64'(bus.avl_read), 64'd1);
      chk("repeat_addr", 64'(bus.avl_address), 64'h100);
      drive_update();
      wait_frame(200);
      chk("repeat_accepts", 64'(acc_cnt), 64'd32);
`else
      repeat (8) step();
      chk("no_repeat_accepts", 64'(acc_cnt), 64'd16);
      chk("no_repeat_read", 64'(bus.avl_read), 64'd0);
`endif
      go_idle();

      // returns withheld: credit limit
      acc_cnt = 0; ret_hold = 1; drv_rd_en = 1'b0;
      repeat (12) step();
      chk("credit_accepts", 64'(acc_cnt), 64'd4);
      chk("credit_read_low", 64'(bus.avl_read), 64'd0);
      ret_hold = 0;
      wait_frame(200);
      chk("credit_frame_accepts", 64'(acc_cnt), 64'd16);
      go_idle();

      // waitrequest for 5 cycles mid-request
      acc_cnt = 0; drv_rd_en = 1'b0;
      wait_acc(3, 50);
      ready_mode = 1;
      repeat (5) step();
      chk("stall_accepts", 64'(acc_cnt), 64'd3);
      chk("stall_read", 64'(bus.avl_read), 64'd1);
      chk("stall_addr", 64'(bus.avl_address), 64'h103);
      ready_mode = 0;
      wait_frame(200);
      chk("stall_frame_accepts", 64'(acc_cnt), 64'd16);
      go_idle();

      // rd_en released after 6 accepts, then resumed
      acc_cnt = 0; fwd_cnt = 0; lat_fix = 3; drv_rd_en = 1'b0;
      stop_after(32'h105, 6, 60);
      repeat (10) step();
      chk("pause_accepts", 64'(acc_cnt), 64'd6);
      chk("pause_forwarded", 64'(fwd_cnt), 64'd6);
      chk("pause_read_low", 64'(bus.avl_read), 64'd0);
      drv_rd_en = 1'b0;
      wait_acc(7, 20);
      chk("resume_addr", 64'(last_acc_addr), 64'h106);
      wait_frame(200);
      go_idle();

      // reset with 3 reads outstanding, late returns must be dropped
      acc_cnt = 0; lat_fix = 2; ret_hold = 1; drv_rd_en = 1'b0;
      stop_after(32'h102, 3, 60);
      repeat (2) step();
      drv_reset = 1'b1;
      step();
      drv_reset = 1'b0;
      ret_hold = 0; fwd_cnt = 0;
      repeat (6) step();
      chk("stray_forwarded", 64'(fwd_cnt), 64'd0);
      chk("stray_valid", 64'(bus.rd_data_valid), 64'd0);
      chk("post_reset_done", 64'(bus.rd_done), 64'd1);
      acc_cnt = 0; drv_rd_en = 1'b0;
      wait_acc(1, 20);
      chk("post_reset_addr", 64'(last_acc_addr), 64'h100);
      wait_frame(200);
      go_idle();

      // random soak
      ready_mode = 2; rnd_ret = 1; rnd_lat = 1; rnd_en = 1; drv_rd_en = 1'b0;
      repeat (3000) step();
      rnd_en = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
